// File: rtl/piso_pkg.sv
// Shared FSM state type and counter sizing helper for the PISO serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Counter sized to hold WIDTH+1 (data plus optional parity) without wrapping.
  function automatic int piso_cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/piso_frame_counter.sv
// Frame bit counter with last-bit detect, parametrised on frame length.
module piso_frame_counter
  import piso_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = piso_cnt_w(FRAME_LEN)
) (
  input  logic Clk,
  input  logic Rst_l,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  // Saturates on the last bit; the next load clears it, so it never wraps.
  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !last) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with per-word bit order selection.
// Optional even-parity bit appended when PISO_SERIALIZER_PARITY_EN is defined.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH             = 8,
  parameter bit MSB_FIRST_DEFAULT = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst_l,
  input  logic             Load_Valid,
  output logic             Load_Ready,
  input  logic [WIDTH-1:0] Parallel_In,
  input  logic             Order_Sel_Valid,
  input  logic             Msb_First,
  input  logic             Shift_En,
  input  logic             Flush,
  output logic             Serial_Out,
  output logic             Serial_Valid,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = piso_cnt_w(WIDTH);
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  piso_state_t      state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             msb_q;
  logic             last_bit;
  logic             load_acc;
  logic             shift_acc;
  logic             data_bit;
  logic             frame_bit;

  assign Load_Ready = (state == IDLE) && !Flush;
  assign Busy       = (state == SHIFT);
  assign load_acc   = Load_Valid && Load_Ready;
  assign shift_acc  = (state == SHIFT) && Shift_En && !Flush;
  assign data_bit   = msb_q ? shreg[WIDTH-1] : shreg[0];

`ifdef PISO_SERIALIZER_PARITY_EN
  logic par_q;

  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l) begin
      par_q <= 1'b0;
    end else if (load_acc) begin
      par_q <= ^Parallel_In;
    end
  end

  // Parity occupies the final frame slot after all data bits.
  assign frame_bit = last_bit ? par_q : data_bit;
`else
  assign frame_bit = data_bit;
`endif

  piso_frame_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) u_frame_counter (
    .Clk   (Clk),
    .Rst_l (Rst_l),
    .clr   (Flush || load_acc),
    .inc   (shift_acc),
    .last  (last_bit)
  );

  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (Flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (Load_Valid) state_nxt = SHIFT;
        SHIFT:   if (Shift_En && last_bit) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output stage: Serial_Out is forced low whenever no frame bit is emitted.
  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l) begin
      shreg        <= '0;
      msb_q        <= 1'b0;
      Serial_Out   <= 1'b0;
      Serial_Valid <= 1'b0;
      Done         <= 1'b0;
    end else if (Flush) begin
      Serial_Out   <= 1'b0;
      Serial_Valid <= 1'b0;
      Done         <= 1'b0;
    end else if (load_acc) begin
      shreg        <= Parallel_In;
      msb_q        <= Order_Sel_Valid ? Msb_First : MSB_FIRST_DEFAULT;
      Serial_Out   <= 1'b0;
      Serial_Valid <= 1'b0;
      Done         <= 1'b0;
    end else if (shift_acc) begin
      shreg        <= msb_q ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
      Serial_Out   <= frame_bit;
      Serial_Valid <= 1'b1;
      Done         <= last_bit;
    end else begin
      Serial_Out   <= 1'b0;
      Serial_Valid <= 1'b0;
      Done         <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: queue-based frame model, randomized traffic.
module tb_piso_serializer;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst_l;
  logic         Load_Valid;
  logic         Load_Ready;
  logic [W-1:0] Parallel_In;
  logic         Order_Sel_Valid;
  logic         Msb_First;
  logic         Shift_En;
  logic         Flush;
  logic         Serial_Out;
  logic         Serial_Valid;
  logic         Busy;
  logic         Done;

  piso_serializer #(.WIDTH(W), .MSB_FIRST_DEFAULT(1'b1)) dut (
    .Clk             (Clk),
    .Rst_l           (Rst_l),
    .Load_Valid      (Load_Valid),
    .Load_Ready      (Load_Ready),
    .Parallel_In     (Parallel_In),
    .Order_Sel_Valid (Order_Sel_Valid),
    .Msb_First       (Msb_First),
    .Shift_En        (Shift_En),
    .Flush           (Flush),
    .Serial_Out      (Serial_Out),
    .Serial_Valid    (Serial_Valid),
    .Busy            (Busy),
    .Done            (Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic b;
    logic d;
    int   cyc;
  } exp_t;

  exp_t exp_q[$];
  logic frame_q[$];
  logic busy_m = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge Clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame contents straight from the word and order: data bits, then optional parity.
  task automatic build_frame(input logic [W-1:0] d, input logic msb);
    frame_q.delete();
    for (int i = 0; i < W; i++) frame_q.push_back(msb ? d[W-1-i] : d[i]);
`ifdef PISO_SERIALIZER_PARITY_EN
    frame_q.push_back(^d);
`endif
  endtask

  task automatic step(input logic lv, input logic [W-1:0] d, input logic osv,
                      input logic m, input logic se, input logic fl);
    logic b;
    @(posedge Clk);
    #1;
    Load_Valid = lv; Parallel_In = d; Order_Sel_Valid = osv;
    Msb_First = m; Shift_En = se; Flush = fl;
    #1;
    chk("load_ready", Load_Ready, !busy_m && !fl);
    chk("busy", Busy, busy_m);
    if (fl) begin
      frame_q.delete();
      busy_m = 1'b0;
    end else if (!busy_m) begin
      if (lv) begin
        build_frame(d, osv ? m : 1'b1);
        busy_m = 1'b1;
      end
    end else if (se) begin
      b = frame_q.pop_front();
      exp_q.push_back('{b: b, d: (frame_q.size() == 0), cyc: cyc + 1});
      if (frame_q.size() == 0) busy_m = 1'b0;
    end
  endtask

  task automatic mid_reset();
    @(negedge Clk);
    #1;
    Rst_l = 1'b0; Load_Valid = 1'b0; Shift_En = 1'b0; Flush = 1'b0;
    #1;
    chk("rst_serial_out", Serial_Out, 1'b0);
    chk("rst_serial_valid", Serial_Valid, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_load_ready", Load_Ready, 1'b1);
    exp_q.delete();
    frame_q.delete();
    busy_m = 1'b0;
    @(negedge Clk);
    #1;
    Rst_l = 1'b1;
  endtask

  // Monitor: pops one expectation per emitted bit; idle cycles must be quiet.
  always @(negedge Clk) begin
    exp_t e;
    if (Serial_Valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bit", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("serial_out", Serial_Out, e.b);
        chk("done", Done, e.d);
        chk("bit_cycle", cyc, e.cyc);
      end
    end else begin
      chk("idle_out_done", {Serial_Out, Done}, 2'b00);
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_bit_cycle", cyc, 0);
      end
    end
  end

  initial begin
    Rst_l = 1'b0; Load_Valid = 1'b0; Parallel_In = '0; Order_Sel_Valid = 1'b0;
    Msb_First = 1'b0; Shift_En = 1'b0; Flush = 1'b0;
    #2;
    chk("reset_serial_out", Serial_Out, 1'b0);
    chk("reset_serial_valid", Serial_Valid, 1'b0);
    chk("reset_done", Done, 1'b0);
    chk("reset_busy", Busy, 1'b0);
    chk("reset_load_ready", Load_Ready, 1'b1);
    Flush = 1'b1;
    #1;
    chk("reset_flush_ready", Load_Ready, 1'b0);
    Flush = 1'b0;
    @(negedge Clk);
    #1;
    Rst_l = 1'b1;

    // 0xC1 MSB-first by default, Shift_En held high
    step(1, 8'hC1, 0, 0, 1, 0);
    repeat (W + 2) step(0, 8'h00, 0, 0, 1, 0);

    // 0xC1 LSB-first through the order override
    step(1, 8'hC1, 1, 0, 1, 0);
    repeat (W + 2) step(0, 8'h00, 0, 0, 1, 0);

    // Shift_En toggling 1,0,1,0
    step(1, 8'hA5, 0, 0, 0, 0);
    for (int i = 0; i < 2 * W + 4; i++) step(0, 8'h00, 0, 0, (i % 2) == 0, 0);

    // Back-to-back 0xC1 then 0x3E with Load_Valid held throughout
    step(1, 8'hC1, 0, 0, 1, 0);
    repeat (W + 1) step(1, 8'h3E, 0, 0, 1, 0);
    repeat (W + 2) step(0, 8'h00, 0, 0, 1, 0);

    // Flush after three bits, then a fresh load once Flush drops
    step(1, 8'hF0, 0, 0, 1, 0);
    repeat (3) step(0, 8'h00, 0, 0, 1, 0);
    step(1, 8'h55, 0, 0, 1, 1);
    step(1, 8'h0F, 1, 0, 1, 0);
    repeat (W + 2) step(0, 8'h00, 0, 0, 1, 0);

    // Reset in mid-frame abandons it with no Done
    step(1, 8'hC1, 0, 0, 1, 0);
    repeat (3) step(0, 8'h00, 0, 0, 1, 0);
    mid_reset();
    step(1, 8'h81, 1, 1, 1, 0);
    repeat (W + 2) step(0, 8'h00, 0, 0, 1, 0);

    // Randomized traffic
    repeat (3000) begin
      step($urandom_range(0, 3) != 0, W'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
    end

    Load_Valid = 1'b0;
    repeat (W + 4) step(0, 8'h00, 0, 0, 1, 0);
    @(negedge Clk);
    #1;
    chk("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
